// File: rtl/gpr_hilo_regfile_pkg.sv
// Shared types for the write-back register file: GPR write port and commit-trace payloads.
package gpr_hilo_regfile_pkg;

    localparam int unsigned REGADDR_W = 5;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned DWORD_W   = 64;

    typedef logic [REGADDR_W-1:0] regaddr_t;
    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [DWORD_W-1:0]   doubleword_t;

    typedef struct packed {
        logic     we;
        regaddr_t waddr;
        word_t    wdata;
    } regWritePort_t;

    typedef struct packed {
        logic     valid;
        word_t    pc;
        logic     we;
        regaddr_t waddr;
        word_t    wdata;
    } commitTrace_t;

    // A write only lands in the architectural file when it targets a register other than $0.
    function automatic logic is_gpr_write(input regWritePort_t wr);
        return wr.we && (wr.waddr != '0);
    endfunction

endpackage

// File: rtl/gpr_hilo_regfile.sv
// Architectural GPR file plus HI/LO with write-first forwarding and a registered commit trace.
module gpr_hilo_regfile
    import gpr_hilo_regfile_pkg::*;
#(
    parameter int unsigned       REG_NUM    = 32,
    parameter logic [DWORD_W-1:0] RESET_HILO = 64'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REGADDR_W-1:0] raddr1,
    input  logic [REGADDR_W-1:0] raddr2,
    output logic [WORD_W-1:0]    rdata1,
    output logic [WORD_W-1:0]    rdata2,
    output logic [DWORD_W-1:0]   hilo,
    input  regWritePort_t        wb_wr,
    input  logic                 wb_hilo_we,
    input  logic [DWORD_W-1:0]   wb_hilo_wdata,
    input  logic                 wb_valid,
    input  logic [WORD_W-1:0]    wb_pc,
    output logic                 trace_valid,
    output logic [WORD_W-1:0]    trace_pc,
    output logic                 trace_we,
    output logic [REGADDR_W-1:0] trace_waddr,
    output logic [WORD_W-1:0]    trace_wdata,
    output logic [WORD_W-1:0]    retire_cnt
);

    word_t        r_gpr [REG_NUM];
    doubleword_t  r_hilo;
    commitTrace_t r_trace;
    word_t        r_retire_cnt;

    logic         w_gpr_we;
    logic         w_trace_we;
    word_t        w_rdata1;
    word_t        w_rdata2;
    doubleword_t  w_hilo;

    assign w_gpr_we   = is_gpr_write(wb_wr);
    assign w_trace_we = wb_valid && w_gpr_we;

    // GPR array; entry 0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_gpr_we) begin
            r_gpr[wb_wr.waddr] <= wb_wr.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hilo <= RESET_HILO;
        end else if (wb_hilo_we) begin
            r_hilo <= wb_hilo_wdata;
        end
    end

    // Write-first read muxes: a same-cycle commit is visible to the ID stage immediately.
    always_comb begin
        w_rdata1 = '0;
        w_rdata2 = '0;
        if (raddr1 != '0) begin
            w_rdata1 = (w_gpr_we && (wb_wr.waddr == raddr1)) ? wb_wr.wdata : r_gpr[raddr1];
        end
        if (raddr2 != '0) begin
            w_rdata2 = (w_gpr_we && (wb_wr.waddr == raddr2)) ? wb_wr.wdata : r_gpr[raddr2];
        end
        w_hilo = wb_hilo_we ? wb_hilo_wdata : r_hilo;
    end

    assign rdata1 = w_rdata1;
    assign rdata2 = w_rdata2;
    assign hilo   = w_hilo;

    // Commit trace for difftest; address/data only advance on a trace-visible GPR write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trace <= '0;
        end else begin
            r_trace.valid <= wb_valid;
            r_trace.pc    <= wb_pc;
            r_trace.we    <= w_trace_we;
            if (w_trace_we) begin
                r_trace.waddr <= wb_wr.waddr;
                r_trace.wdata <= wb_wr.wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (wb_valid) begin
            r_retire_cnt <= r_retire_cnt + WORD_W'(1);
        end
    end

    assign trace_valid = r_trace.valid;
    assign trace_pc    = r_trace.pc;
    assign trace_we    = r_trace.we;
    assign trace_waddr = r_trace.waddr;
    assign trace_wdata = r_trace.wdata;
    assign retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_gpr_hilo_regfile.sv
// Directed self-checking bench for gpr_hilo_regfile.
module tb_gpr_hilo_regfile;
    import gpr_hilo_regfile_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    raddr1, raddr2;
    logic [31:0]   rdata1, rdata2;
    logic [63:0]   hilo;
    regWritePort_t wb_wr;
    logic          wb_hilo_we;
    logic [63:0]   wb_hilo_wdata;
    logic          wb_valid;
    logic [31:0]   wb_pc;
    logic          trace_valid, trace_we;
    logic [31:0]   trace_pc, trace_wdata, retire_cnt;
    logic [4:0]    trace_waddr;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   exp_cnt;
    logic [31:0]   pcs [3];

    gpr_hilo_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2), .hilo(hilo),
        .wb_wr(wb_wr), .wb_hilo_we(wb_hilo_we), .wb_hilo_wdata(wb_hilo_wdata),
        .wb_valid(wb_valid), .wb_pc(wb_pc),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_we(trace_we),
        .trace_waddr(trace_waddr), .trace_wdata(trace_wdata), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Rising edge with the bench's own retire-count model, then settle.
    task automatic tick();
        @(posedge clk);
        if (rst_n && wb_valid) exp_cnt = exp_cnt + 32'd1;
        #1;
    endtask

    task automatic idle_inputs();
        wb_wr         = '0;
        wb_hilo_we    = 1'b0;
        wb_hilo_wdata = '0;
        wb_valid      = 1'b0;
        wb_pc         = '0;
    endtask

    initial begin
        exp_cnt = '0;
        pcs[0] = 32'hBFC0_0000; pcs[1] = 32'hBFC0_0004; pcs[2] = 32'hBFC0_0008;
        rst_n = 1'b0; raddr1 = '0; raddr2 = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state over every address on both ports
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a);
            #1;
            chk("rst_rdata1", 64'(rdata1), 64'h0);
            chk("rst_rdata2", 64'(rdata2), 64'h0);
        end
        chk("rst_hilo", hilo, 64'h0);
        chk("rst_retire_cnt", 64'(retire_cnt), 64'h0);
        chk("rst_trace_valid", 64'(trace_valid), 64'h0);

        // Write r5 with same-cycle forwarding, then read from the array
        @(negedge clk);
        wb_wr = '{we: 1'b1, waddr: 5'd5, wdata: 32'hDEAD_BEEF};
        raddr1 = 5'd5; raddr2 = 5'd6;
        #1;
        chk("fwd_rdata1", 64'(rdata1), 64'hDEAD_BEEF);
        chk("fwd_other_port", 64'(rdata2), 64'h0);
        tick();
        chk("trace_we_no_valid", 64'(trace_we), 64'h0);
        @(negedge clk);
        wb_wr.we = 1'b0;
        #1;
        chk("held_rdata1", 64'(rdata1), 64'hDEAD_BEEF);

        // $0 protection, retiring so the trace sees the instruction
        @(negedge clk);
        wb_wr = '{we: 1'b1, waddr: 5'd0, wdata: 32'h0000_1234};
        wb_valid = 1'b1; wb_pc = 32'h0000_0100; raddr1 = 5'd0;
        #1;
        chk("r0_same_cycle", 64'(rdata1), 64'h0);
        tick();
        chk("r0_trace_we", 64'(trace_we), 64'h0);
        chk("r0_trace_valid", 64'(trace_valid), 64'h1);
        chk("r0_trace_pc", 64'(trace_pc), 64'h100);
        chk("r0_trace_waddr_hold", 64'(trace_waddr), 64'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("r0_after", 64'(rdata1), 64'h0);

        // Retired write to r7 updates trace address/data
        @(negedge clk);
        wb_wr = '{we: 1'b1, waddr: 5'd7, wdata: 32'hA5A5_A5A5};
        wb_valid = 1'b1; wb_pc = 32'h0000_0200;
        tick();
        chk("r7_trace_we", 64'(trace_we), 64'h1);
        chk("r7_trace_waddr", 64'(trace_waddr), 64'h7);
        chk("r7_trace_wdata", 64'(trace_wdata), 64'hA5A5_A5A5);
        chk("r7_retire_cnt", 64'(retire_cnt), 64'(exp_cnt));

        // Dual read of r7 with a same-cycle HILO write
        @(negedge clk);
        idle_inputs();
        raddr1 = 5'd7; raddr2 = 5'd7;
        wb_hilo_we = 1'b1; wb_hilo_wdata = 64'h0000_0001_0000_0002;
        #1;
        chk("dual_rdata1", 64'(rdata1), 64'hA5A5_A5A5);
        chk("dual_rdata2", 64'(rdata2), 64'hA5A5_A5A5);
        chk("hilo_fwd", hilo, 64'h0000_0001_0000_0002);
        tick();
        chk("trace_valid_drop", 64'(trace_valid), 64'h0);
        chk("trace_waddr_hold", 64'(trace_waddr), 64'h7);
        @(negedge clk);
        wb_hilo_we = 1'b0; wb_hilo_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("hilo_held", hilo, 64'h0000_0001_0000_0002);

        // Simultaneous GPR and HILO commits, forwarding on port 2 only
        @(negedge clk);
        wb_wr = '{we: 1'b1, waddr: 5'd9, wdata: 32'h0000_0099};
        wb_hilo_we = 1'b1; wb_hilo_wdata = 64'hCAFE_0000_0000_BABE;
        raddr1 = 5'd5; raddr2 = 5'd9;
        #1;
        chk("mix_rdata1", 64'(rdata1), 64'hDEAD_BEEF);
        chk("mix_rdata2_fwd", 64'(rdata2), 64'h99);
        tick();
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mix_rdata2_mem", 64'(rdata2), 64'h99);
        chk("mix_hilo_mem", hilo, 64'hCAFE_0000_0000_BABE);

        // Three back-to-back retires, trace PC one cycle behind
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wb_valid = 1'b1; wb_pc = pcs[k];
            tick();
            chk("trace_pc_seq", 64'(trace_pc), 64'(pcs[k]));
        end
        chk("retire_cnt_seq", 64'(retire_cnt), 64'(exp_cnt));
        chk("retire_cnt_abs", 64'(retire_cnt), 64'h5);

        // Counter wrap from all-ones
        @(negedge clk);
        wb_valid = 1'b0;
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        wb_valid = 1'b1;
        tick();
        chk("retire_cnt_wrap", 64'(retire_cnt), 64'h0);

        // Asynchronous reset mid-write
        @(negedge clk);
        wb_wr = '{we: 1'b1, waddr: 5'd12, wdata: 32'h1212_1212};
        wb_valid = 1'b1; wb_pc = 32'h0000_0300;
        raddr1 = 5'd5; raddr2 = 5'd7;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rdata1", 64'(rdata1), 64'h0);
        chk("arst_rdata2", 64'(rdata2), 64'h0);
        chk("arst_hilo", hilo, 64'h0);
        chk("arst_retire_cnt", 64'(retire_cnt), 64'h0);
        chk("arst_trace_valid", 64'(trace_valid), 64'h0);
        exp_cnt = '0;
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        raddr1 = 5'd12;
        #1;
        chk("arst_r12_lost", 64'(rdata1), 64'h0);
        chk("arst_trace_pc", 64'(trace_pc), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
